conf_buffer: RTL and testbench
==============================

Name: conf_buffer

Overview:
Upstream configuration queue for Main_controller.
- Host writes a GEMM tile descriptor field-by-field into staging registers, then commits it into a FIFO.
- The FIFO head drives the controller's configuration inputs (msize, nsize, ksize, tile addresses and strides, mode, store) together with conf_empty.
- The controller pops an entry with conf_buff_read once it has consumed the descriptor.

Parameters:
DEPTH, 4, number of queued descriptors; power of 2, >=2
AW, 32, address/stride width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wr_en  in  1  host register write strobe
wr_addr  in  3  host register index
wr_data  in  32  host write data
conf_buff_read  in  1  pop head descriptor (from controller)
msize  out  5  head M size
nsize  out  5  head N size
ksize  out  5  head K size
mode  out  2  head operating mode
store  out  1  head store flag
tile_A_addr  out  AW  head A base
tile_B_addr  out  AW  head B base
tile_A_stride  out  AW  head A stride
tile_B_stride  out  AW  head B stride
tile_C_addr  out  AW  head C base
conf_empty  out  1  queue empty
conf_full  out  1  queue full
conf_count  out  $clog2(DEPTH)+1  entries held
err_overflow  out  1  sticky: commit while full
err_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (rst low, asynchronous): pointers = 0; staging registers = 0; error flags = 0. Outputs after reset: conf_empty = 1, conf_full = 0, conf_count = 0, all head fields = 0.
- Register map (wr_en high, applied at the rising edge):
  - 0 SIZES: [4:0] msize, [9:5] nsize, [14:10] ksize, [17:16] mode, [18] store.
  - 1 A_ADDR, 2 B_ADDR, 3 A_STRIDE, 4 B_STRIDE, 5 C_ADDR.
  - 6 COMMIT: data ignored; pushes the staged descriptor.
  - 7 FLUSH: empties the queue and clears both error flags; staging is untouched.
- Staging registers keep their value after COMMIT, so the host rewrites only the fields that change.
- Commit latency: a COMMIT at edge N makes conf_empty = 0 and the head valid from cycle N+1. A staging write and a COMMIT cannot coincide (single write port).
- Head fields are combinational reads of the storage at the read pointer, forced to 0 while conf_empty = 1.
- Pop: conf_buff_read at edge N advances the read pointer; the next entry is visible from cycle N+1.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - conf_empty = (wptr == rptr).
  - conf_full = (MSB differs, rest equal).
  - conf_count = wptr - rptr.
- Full / overflow: full is judged on the pre-edge state. A COMMIT while full is dropped and sets err_overflow, even if a pop occurs in the same cycle.
- Empty / underflow: a pop while empty is ignored and sets err_underflow. COMMIT and pop together while empty: the commit is accepted, the pop is ignored, and err_underflow is set.
- COMMIT and pop together, neither full nor empty: both take effect; count unchanged.
- FLUSH and pop in the same cycle: FLUSH wins; no underflow is flagged.
- Sticky errors clear only on FLUSH or reset.
- Reset asserted mid-operation: all queued descriptors are discarded immediately.

Optional Feature:
CONF_BUFFER_SIZE_CHECK_EN
- Defined:
  - COMMIT is rejected if any of msize/nsize/ksize is 0 or > 16, or if mode == 2'b11.
  - A rejected commit sets a sticky err_size output port (1 bit, cleared by FLUSH/reset) and leaves the queue unchanged.
  - Size check and full check are evaluated independently; both flags may set in the same cycle.
- Undefined: the err_size port is absent and every COMMIT while not full is accepted unvalidated.

Decomposition:
- Package conf_pkg:
  - conf_desc_t packed struct (msize, nsize, ksize, mode, store, tile_A_addr, tile_B_addr, tile_A_stride, tile_B_stride, tile_C_addr).
  - localparams REG_SIZES..REG_FLUSH for indices 0..7.
  - MAX_DIM = 16.
- One sub-module, conf_fifo: generic synchronous FIFO of conf_desc_t with push/pop/flush, empty/full/count, asynchronous active-low reset.
- conf_buffer holds the staging registers, address decode, validation and error flags.

Test Plan:
- Reset -> conf_empty = 1, conf_count = 0, head fields 0. Write SIZES = {store=1, mode=1, k=8, n=12, m=16}, A_ADDR = 0x1000, C_ADDR = 0x3000, COMMIT -> next cycle conf_empty = 0, msize = 16, nsize = 12, ksize = 8, tile_A_addr = 0x1000, tile_C_addr = 0x3000.
- Commit DEPTH = 4 descriptors with A_ADDR 0x100, 0x200, 0x300, 0x400 -> conf_full = 1, conf_count = 4. Fifth COMMIT -> err_overflow = 1, count stays 4. Pop four times -> A_ADDR order 0x100..0x400, then conf_empty = 1.
- Pop while empty -> err_underflow = 1, pointers unchanged. FLUSH -> err_underflow = 0.
- Fill 3 entries, then COMMIT and pop in the same cycle, repeated 6 times -> count stays 3, FIFO order preserved across pointer wrap.
- Full queue, COMMIT and pop in the same cycle -> count = 3, err_overflow = 1.
- With CONF_BUFFER_SIZE_CHECK_EN: COMMIT with nsize = 17 -> err_size = 1, conf_count unchanged. COMMIT with nsize = 16 -> accepted. Drop rst low mid-queue -> conf_empty = 1 asynchronously, err_size = 0.

Source files
------------

// File: rtl/conf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conf_pkg
// Brief    : Shared types and constants for the conf_buffer descriptor queue.
// Revision : 1.0 - initial release
// ============================================================================
package conf_pkg;

  // Width of every address/stride field held in a descriptor
  localparam int CONF_AW = 32;

  // Host register map
  localparam logic [2:0] REG_SIZES    = 3'd0;
  localparam logic [2:0] REG_A_ADDR   = 3'd1;
  localparam logic [2:0] REG_B_ADDR   = 3'd2;
  localparam logic [2:0] REG_A_STRIDE = 3'd3;
  localparam logic [2:0] REG_B_STRIDE = 3'd4;
  localparam logic [2:0] REG_C_ADDR   = 3'd5;
  localparam logic [2:0] REG_COMMIT   = 3'd6;
  localparam logic [2:0] REG_FLUSH    = 3'd7;

  // Largest legal M/N/K tile dimension
  localparam int MAX_DIM = 16;

  typedef struct packed {
    logic [4:0]         msize;
    logic [4:0]         nsize;
    logic [4:0]         ksize;
    logic [1:0]         mode;
    logic               store;
    logic [CONF_AW-1:0] tile_A_addr;
    logic [CONF_AW-1:0] tile_B_addr;
    logic [CONF_AW-1:0] tile_A_stride;
    logic [CONF_AW-1:0] tile_B_stride;
    logic [CONF_AW-1:0] tile_C_addr;
  } conf_desc_t;

  // A tile dimension is usable when it is in 1..MAX_DIM
  function automatic logic dim_ok(input logic [4:0] d);
    return (d != 5'd0) && (d <= 5'(MAX_DIM));
  endfunction

endpackage
`default_nettype wire

// File: rtl/conf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conf_fifo
// Brief    : Synchronous FIFO of conf_desc_t with push/pop/flush and
//            empty/full/count status. Head is a combinational read, zeroed
//            while empty. Pointers carry one extra wrap bit.
// Revision : 1.0 - initial release
// ============================================================================
module conf_fifo
  import conf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  conf_desc_t push_data,
  input  logic       pop,
  input  logic       flush,
  output conf_desc_t head,
  output logic       empty,
  output logic       full,
  output logic [PW:0] count
);

  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  logic        push_ok;
  logic        pop_ok;
  conf_desc_t  mem_q [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count = wptr_q - rptr_q;
  assign head  = empty ? '0 : mem_q[rptr_q[PW-1:0]];

  // Next pointer values; flush overrides both push and pop
  always_comb begin
    push_ok = push && !full && !flush;
    pop_ok  = pop && !empty && !flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers; reset discards all queued entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Descriptor storage; contents are only visible through head when non-empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[PW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/conf_buffer.sv
`default_nettype none
// ============================================================================
// Module   : conf_buffer
// Brief    : Host-written staging registers for a GEMM tile descriptor,
//            committed into a descriptor FIFO whose head feeds the
//            controller. Tracks sticky overflow/underflow errors.
//            Optional macro CONF_BUFFER_SIZE_CHECK_EN validates sizes/mode on
//            COMMIT and adds the sticky err_size port.
// Revision : 1.0 - initial release
// ============================================================================
module conf_buffer
  import conf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [2:0]               wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     conf_buff_read,
  output logic [4:0]               msize,
  output logic [4:0]               nsize,
  output logic [4:0]               ksize,
  output logic [1:0]               mode,
  output logic                     store,
  output logic [AW-1:0]            tile_A_addr,
  output logic [AW-1:0]            tile_B_addr,
  output logic [AW-1:0]            tile_A_stride,
  output logic [AW-1:0]            tile_B_stride,
  output logic [AW-1:0]            tile_C_addr,
  output logic                     conf_empty,
  output logic                     conf_full,
  output logic [$clog2(DEPTH):0]   conf_count,
  output logic                     err_overflow,
  output logic                     err_underflow
`ifdef CONF_BUFFER_SIZE_CHECK_EN
  ,
  output logic                     err_size
`endif
);

  // Descriptor fields are fixed-width in the package
  if (AW != CONF_AW) begin : g_aw_check
    $error("conf_buffer: AW must equal conf_pkg::CONF_AW");
  end

  conf_desc_t stage_q, stage_d;
  conf_desc_t head;
  logic       commit, flush, size_ok, push;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic       esz_q, esz_d;

  assign commit = wr_en && (wr_addr == REG_COMMIT);
  assign flush  = wr_en && (wr_addr == REG_FLUSH);

`ifdef CONF_BUFFER_SIZE_CHECK_EN
  assign size_ok = dim_ok(stage_q.msize) && dim_ok(stage_q.nsize) &&
                   dim_ok(stage_q.ksize) && (stage_q.mode != 2'b11);
`else
  assign size_ok = 1'b1;
`endif

  assign push = commit && size_ok;

  conf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (stage_q),
    .pop       (conf_buff_read),
    .flush     (flush),
    .head      (head),
    .empty     (conf_empty),
    .full      (conf_full),
    .count     (conf_count)
  );

  // Register-map decode into the staging descriptor
  always_comb begin
    stage_d = stage_q;
    if (wr_en) begin
      case (wr_addr)
        REG_SIZES: begin
          stage_d.msize = wr_data[4:0];
          stage_d.nsize = wr_data[9:5];
          stage_d.ksize = wr_data[14:10];
          stage_d.mode  = wr_data[17:16];
          stage_d.store = wr_data[18];
        end
        REG_A_ADDR:   stage_d.tile_A_addr   = wr_data;
        REG_B_ADDR:   stage_d.tile_B_addr   = wr_data;
        REG_A_STRIDE: stage_d.tile_A_stride = wr_data;
        REG_B_STRIDE: stage_d.tile_B_stride = wr_data;
        REG_C_ADDR:   stage_d.tile_C_addr   = wr_data;
        default: ;
      endcase
    end
  end

  // Sticky errors, judged on pre-edge full/empty; FLUSH clears and masks them
  always_comb begin
    ovf_d = ovf_q | (commit & conf_full);
    udf_d = udf_q | (conf_buff_read & conf_empty);
    esz_d = esz_q | (commit & ~size_ok);
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
      esz_d = 1'b0;
    end
  end

  // Staging and error state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      esz_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      esz_q   <= esz_d;
    end
  end

  assign msize         = head.msize;
  assign nsize         = head.nsize;
  assign ksize         = head.ksize;
  assign mode          = head.mode;
  assign store         = head.store;
  assign tile_A_addr   = head.tile_A_addr;
  assign tile_B_addr   = head.tile_B_addr;
  assign tile_A_stride = head.tile_A_stride;
  assign tile_B_stride = head.tile_B_stride;
  assign tile_C_addr   = head.tile_C_addr;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
  assign err_size      = esz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conf_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conf_buffer
// Brief    : Randomized self-checking bench for conf_buffer against a
//            queue-based reference model. Honours CONF_BUFFER_SIZE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conf_buffer;
  import conf_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        conf_buff_read = 1'b0;
  logic [4:0]  msize, nsize, ksize;
  logic [1:0]  mode;
  logic        store;
  logic [AW-1:0] tile_A_addr, tile_B_addr, tile_A_stride, tile_B_stride, tile_C_addr;
  logic        conf_empty, conf_full, err_overflow, err_underflow;
  logic [$clog2(DEPTH):0] conf_count;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
  logic        err_size;
`endif

  conf_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .conf_buff_read(conf_buff_read),
    .msize(msize), .nsize(nsize), .ksize(ksize), .mode(mode), .store(store),
    .tile_A_addr(tile_A_addr), .tile_B_addr(tile_B_addr),
    .tile_A_stride(tile_A_stride), .tile_B_stride(tile_B_stride),
    .tile_C_addr(tile_C_addr),
    .conf_empty(conf_empty), .conf_full(conf_full), .conf_count(conf_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
`ifdef CONF_BUFFER_SIZE_CHECK_EN
    , .err_size(err_size)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  conf_desc_t m_q[$];
  conf_desc_t m_stage;
  bit m_ovf, m_udf;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
  bit m_esz;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    conf_desc_t e;
    e = (m_q.size() != 0) ? m_q[0] : '0;
    chk({ctx, ".msize"}, 64'(msize), 64'(e.msize));
    chk({ctx, ".nsize"}, 64'(nsize), 64'(e.nsize));
    chk({ctx, ".ksize"}, 64'(ksize), 64'(e.ksize));
    chk({ctx, ".mode"},  64'(mode),  64'(e.mode));
    chk({ctx, ".store"}, 64'(store), 64'(e.store));
    chk({ctx, ".a_addr"}, 64'(tile_A_addr), 64'(e.tile_A_addr));
    chk({ctx, ".b_addr"}, 64'(tile_B_addr), 64'(e.tile_B_addr));
    chk({ctx, ".a_stride"}, 64'(tile_A_stride), 64'(e.tile_A_stride));
    chk({ctx, ".b_stride"}, 64'(tile_B_stride), 64'(e.tile_B_stride));
    chk({ctx, ".c_addr"}, 64'(tile_C_addr), 64'(e.tile_C_addr));
    chk({ctx, ".count"}, 64'(conf_count), 64'(m_q.size()));
    chk({ctx, ".empty"}, 64'(conf_empty), 64'(m_q.size() == 0));
    chk({ctx, ".full"},  64'(conf_full),  64'(m_q.size() == DEPTH));
    chk({ctx, ".ovf"},   64'(err_overflow),  64'(m_ovf));
    chk({ctx, ".udf"},   64'(err_underflow), 64'(m_udf));
`ifdef CONF_BUFFER_SIZE_CHECK_EN
    chk({ctx, ".esz"},   64'(err_size), 64'(m_esz));
`endif
  endtask

  // One clock of host/controller activity, applied to the model at the edge
  task automatic model(input logic we, input logic [2:0] a, input logic [31:0] d, input logic rd);
    bit commit, flush, full, empty, ok;
    commit = we && (a == 3'd6);
    flush  = we && (a == 3'd7);
    full   = (m_q.size() == DEPTH);
    empty  = (m_q.size() == 0);
    ok     = 1'b1;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
    ok = (m_stage.msize inside {[1:16]}) && (m_stage.nsize inside {[1:16]}) &&
         (m_stage.ksize inside {[1:16]}) && (m_stage.mode != 2'd3);
`endif
    if (flush) begin
      m_q.delete();
      m_ovf = 0;
      m_udf = 0;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
      m_esz = 0;
`endif
    end else begin
      if (commit && full) m_ovf = 1;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
      if (commit && !ok) m_esz = 1;
`endif
      if (rd) begin
        if (empty) m_udf = 1;
        else void'(m_q.pop_front());
      end
      if (commit && !full && ok) m_q.push_back(m_stage);
    end
    if (we) begin
      case (a)
        3'd0: begin
          m_stage.msize = d[4:0];
          m_stage.nsize = d[9:5];
          m_stage.ksize = d[14:10];
          m_stage.mode  = d[17:16];
          m_stage.store = d[18];
        end
        3'd1: m_stage.tile_A_addr   = d;
        3'd2: m_stage.tile_B_addr   = d;
        3'd3: m_stage.tile_A_stride = d;
        3'd4: m_stage.tile_B_stride = d;
        3'd5: m_stage.tile_C_addr   = d;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stage = '0;
    m_ovf = 0;
    m_udf = 0;
`ifdef CONF_BUFFER_SIZE_CHECK_EN
    m_esz = 0;
`endif
  endtask

  task automatic step(input string ctx, input logic we, input logic [2:0] a,
                      input logic [31:0] d, input logic rd);
    wr_en = we; wr_addr = a; wr_data = d; conf_buff_read = rd;
    @(posedge clk);
    model(we, a, d, rd);
    #1;
    check_all(ctx);
    wr_en = 1'b0; conf_buff_read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step("wr", 1'b1, a, d, 1'b0);
  endtask

  task automatic pop_one();
    step("pop", 1'b0, 3'd0, 32'd0, 1'b1);
  endtask

  function automatic logic [31:0] sizes(input int m, input int n, input int k,
                                        input int md, input int st);
    return 32'((st << 18) | (md << 16) | (k << 10) | (n << 5) | m);
  endfunction

  task automatic async_reset(input string ctx);
    wr_en = 1'b0; conf_buff_read = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // First descriptor reaches the head one cycle after COMMIT
    wr(3'd0, sizes(16, 12, 8, 1, 1));
    wr(3'd1, 32'h1000);
    wr(3'd5, 32'h3000);
    step("commit1", 1'b1, 3'd6, 32'd0, 1'b0);
    chk("d1.empty", 64'(conf_empty), 64'd0);
    chk("d1.msize", 64'(msize), 64'd16);
    chk("d1.nsize", 64'(nsize), 64'd12);
    chk("d1.ksize", 64'(ksize), 64'd8);
    chk("d1.a_addr", 64'(tile_A_addr), 64'h1000);
    chk("d1.c_addr", 64'(tile_C_addr), 64'h3000);
    pop_one();

    // Fill to full, overflow, drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      wr(3'd1, 32'(i * 32'h100));
      step("fill", 1'b1, 3'd6, 32'd0, 1'b0);
    end
    chk("d2.full", 64'(conf_full), 64'd1);
    chk("d2.count", 64'(conf_count), 64'd4);
    step("ovf", 1'b1, 3'd6, 32'd0, 1'b0);
    chk("d2.ovf", 64'(err_overflow), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("d2.order", 64'(tile_A_addr), 64'(i * 32'h100));
      pop_one();
    end
    chk("d2.empty", 64'(conf_empty), 64'd1);

    // Underflow then flush
    pop_one();
    chk("d3.udf", 64'(err_underflow), 64'd1);
    step("flush", 1'b1, 3'd7, 32'd0, 1'b0);
    chk("d3.udf_clr", 64'(err_underflow), 64'd0);

    // Steady-state commit+pop across pointer wrap
    for (int i = 0; i < 3; i++) begin
      wr(3'd1, 32'h5000 + 32'(i));
      step("fill3", 1'b1, 3'd6, 32'd0, 1'b0);
    end
    for (int i = 3; i < 9; i++) begin
      wr(3'd1, 32'h5000 + 32'(i));
      step("cp", 1'b1, 3'd6, 32'd0, 1'b1);
      chk("d4.count", 64'(conf_count), 64'd3);
    end

    // Full queue with commit+pop: commit dropped, pop taken
    step("fill4", 1'b1, 3'd6, 32'd0, 1'b0);
    step("full_cp", 1'b1, 3'd6, 32'd0, 1'b1);
    chk("d5.count", 64'(conf_count), 64'd3);
    chk("d5.ovf", 64'(err_overflow), 64'd1);
    step("flush2", 1'b1, 3'd7, 32'd0, 1'b0);

`ifdef CONF_BUFFER_SIZE_CHECK_EN
    wr(3'd0, sizes(4, 17, 4, 0, 0));
    step("bad_size", 1'b1, 3'd6, 32'd0, 1'b0);
    chk("d6.esz", 64'(err_size), 64'd1);
    chk("d6.count", 64'(conf_count), 64'd0);
    wr(3'd0, sizes(4, 16, 4, 0, 0));
    step("good_size", 1'b1, 3'd6, 32'd0, 1'b0);
    chk("d6.count2", 64'(conf_count), 64'd1);
`endif
    async_reset("mid_reset");
    chk("d7.empty", 64'(conf_empty), 64'd1);

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      logic [2:0]  a;
      logic [31:0] d;
      logic        we, rd;
      r  = int'($urandom_range(0, 99));
      rd = ($urandom_range(0, 99) < 35);
      we = 1'b1;
      a  = 3'd0;
      d  = $urandom;
      if (r < 12) begin
        a = 3'd0;
        d = sizes(int'($urandom_range(0, 18)), int'($urandom_range(0, 18)),
                  int'($urandom_range(0, 18)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)));
      end else if (r < 32) begin
        a = 3'(int'($urandom_range(1, 5)));
      end else if (r < 65) begin
        a = 3'd6;
      end else if (r < 67) begin
        a = 3'd7;
      end else begin
        we = 1'b0;
      end
      step("rand", we, a, d, rd);
      if (it == 300) async_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
